reg_dump_reader: RTL
====================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter WIDTH, default 8: data width of the register-file read ports and of DOUT.
REQ-002 Parameter NREGS, default 8: number of registers dumped; SHALL be even, 2..8.
REQ-003 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 START  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-006 OUT1ADDRESS  output  3  register-file read port 1 address; registered.
REQ-007 OUT2ADDRESS  output  3  register-file read port 2 address; registered.
REQ-008 OUT1  input  WIDTH  register-file read port 1 data.
REQ-009 OUT2  input  WIDTH  register-file read port 2 data.
REQ-010 DOUT  output  WIDTH  streamed register value; registered.
REQ-011 DADDR  output  3  register index of the current DOUT.
REQ-012 DVALID  output  1  DOUT/DADDR valid.
REQ-013 DREADY  input  1  sink accepts; a transfer occurs on an edge where DVALID=1 and DREADY=1.
REQ-014 BUSY  output  1  high from the first cycle after START is accepted until DONE is asserted.
REQ-015 DONE  output  1  single-cycle pulse after the last transfer.

Function
REQ-016 FSM states: IDLE, ADDR, CAPTURE, SEND1, SEND2, FIN.
REQ-017 IDLE: START=1 -> ADDR; pair counter k cleared to 0; OUT1ADDRESS=0 and OUT2ADDRESS=1 loaded on the same edge.
REQ-018 ADDR: one settle cycle, with OUT1ADDRESS=2k and OUT2ADDRESS=2k+1 held -> CAPTURE unconditionally.
REQ-019 CAPTURE: OUT1 and OUT2 are latched into holding registers H1 and H2 on the exiting edge -> SEND1; DOUT=H1, DADDR=2k, DVALID=1 loaded on that edge.
REQ-020 SEND1: hold DOUT, DADDR and DVALID stable while DREADY=0; on transfer -> SEND2 with DOUT=H2, DADDR=2k+1, DVALID kept at 1.
REQ-021 SEND2: on transfer, if 2k+2=NREGS -> FIN with DVALID=0; otherwise k increments, both addresses advance by 2, DVALID=0, and the FSM goes to ADDR.
REQ-022 FIN: DONE=1 and BUSY=0 for exactly one cycle -> IDLE.
REQ-023 START in any state other than IDLE SHALL be ignored; START coinciding with FIN SHALL be ignored.
REQ-024 Latency: START sampled at edge n -> DVALID=1 after edge n+2 (DADDR=0).
REQ-025 With DREADY held high, a full dump SHALL take 2*NREGS cycles from START to FIN (NREGS=8: 16 cycles), then a DONE pulse.
REQ-026 DVALID SHALL never drop without a transfer; DOUT SHALL never change while DVALID=1 and DREADY=0.
REQ-027 Register-file data SHALL be sampled only at the CAPTURE exit edge; changes on OUT1/OUT2 at any other time have no effect on DOUT.
REQ-028 In IDLE, OUT1ADDRESS and OUT2ADDRESS SHALL hold their last values.

Reset
REQ-029 RESET=1 at an edge -> state IDLE, k=0, OUT1ADDRESS=0, OUT2ADDRESS=0, DOUT=0, DADDR=0, DVALID=0, BUSY=0, DONE=0, H1=H2=0.
REQ-030 RESET overrides START and any in-flight transfer; a dump aborted by reset SHALL NOT produce DONE.
REQ-031 RESET asserted while DVALID=1 and DREADY=1 SHALL NOT count as a completed transfer.

Verification
REQ-032 Register file preloaded with R[i]=8'h10+i, DREADY=1, one START pulse -> 8 transfers: DADDR 0..7, DOUT 8'h10..8'h17, in order and back-to-back within each pair; DONE 16 cycles after START; BUSY low on the DONE cycle.
REQ-033 Same preload, DREADY=0 for 5 cycles once DVALID rises for DADDR=3 -> DOUT stays at 8'h13 and DADDR at 3 throughout the stall; the sequence resumes with no loss or duplication.
REQ-034 START pulsed again at DADDR=4 mid-dump -> ignored; exactly 8 transfers and one DONE.
REQ-035 RESET at DADDR=5 -> DVALID=0 and BUSY=0 on the next edge, no DONE; a new START then dumps from DADDR=0.
REQ-036 R[2] rewritten from 8'h12 to 8'hAA after the CAPTURE edge of pair 1 and before its transfer -> DOUT=8'h12 for DADDR=2.
REQ-037 NREGS=4 -> 4 transfers, DADDR 0..3, DONE 8 cycles after START.

Source files
------------

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams a register file out pairwise over a valid/ready port
//
// Purpose:
//    On a START pulse, walks NREGS registers two at a time through a
//    dual-read-port register file and presents each value on DOUT/DADDR
//    with a valid/ready handshake. It signals DONE once the last value
//    has been taken.
//
// Ports:
//    clk          system clock, all state changes on the rising edge
//    reset        synchronous active-high reset
//    start        single-cycle dump request, honoured only in IDLE
//    out1address  read port 1 address (even register of the pair), registered
//    out2address  read port 2 address (odd register of the pair), registered
//    out1, out2   read port 1/2 data
//    dout         streamed register value, registered
//    daddr        register index of dout
//    dvalid       dout/daddr valid
//    dready       sink accepts; a transfer is dvalid & dready at an edge
//    busy         high while a dump is in progress
//    done         one-cycle pulse after the last transfer

module reg_dump_reader #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [2:0]       out1address,
   output logic [2:0]       out2address,
   input  logic [WIDTH-1:0] out1,
   input  logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] dout,
   output logic [2:0]       daddr,
   output logic             dvalid,
   input  logic             dready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CAPTURE,
      SEND1,
      SEND2,
      FIN
   } state_t;

   // Index of the final pair; NREGS is even and at most 8, so k fits in 2 bits.
   localparam logic [1:0] LAST_K = 2'(NREGS / 2 - 1);

   state_t           state;
   logic [1:0]       k;
   logic [WIDTH-1:0] h2;

   // The even register goes straight from OUT1 into dout at the capture
   // edge, so only the odd register needs a holding register until SEND2.
   logic xfer;
   assign xfer = dvalid & dready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         k           <= 2'd0;
         out1address <= 3'd0;
         out2address <= 3'd0;
         dout        <= '0;
         daddr       <= 3'd0;
         dvalid      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         h2          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Addresses keep their last values until a new dump starts.
               if (start) begin
                  state       <= ADDR;
                  k           <= 2'd0;
                  out1address <= 3'd0;
                  out2address <= 3'd1;
                  busy        <= 1'b1;
               end
            end
            ADDR: begin
               // Settle cycle so the register file sees the new addresses.
               state <= CAPTURE;
            end
            CAPTURE: begin
               h2     <= out2;
               dout   <= out1;
               daddr  <= {k, 1'b0};
               dvalid <= 1'b1;
               state  <= SEND1;
            end
            SEND1: begin
               if (xfer) begin
                  dout  <= h2;
                  daddr <= {k, 1'b1};
                  state <= SEND2;
               end
            end
            SEND2: begin
               if (xfer) begin
                  dvalid <= 1'b0;
                  if (k == LAST_K) begin
                     state <= FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     k           <= k + 2'd1;
                     out1address <= out1address + 3'd2;
                     out2address <= out2address + 3'd2;
                     state       <= ADDR;
                  end
               end
            end
            FIN: begin
               // start is deliberately not looked at here.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
